// File: rtl/byte_serial_ram_bridge.sv
// byte_serial_ram_bridge
//   Byte-serial front-end for a word-wide, byte-writable synchronous RAM.
//   A write command collects BYTES input bytes (lane 0 first) and commits
//   them as one full-word write; a read command fetches one word and
//   streams it out LSB-first on dout/dout_valid.
//   All RAM-side outputs come straight from registered state, so there is
//   no combinational path from the command pins to the macro.
//   Optional feature macro: BRIDGE_AUTO_INC_EN (cmd_inc selects last+1).
module byte_serial_ram_bridge #(
  parameter int ADDR_W = 3,
  parameter int BYTES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic                cmd_inc,
  input  logic                cmd_abort,
  input  logic [7:0]          din,
  input  logic                din_valid,
  output logic [7:0]          dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                ram_en,
  output logic [BYTES-1:0]    ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [8*BYTES-1:0]  ram_wdata,
  input  logic [8*BYTES-1:0]  ram_rdata
);

  localparam int W     = 8 * BYTES;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WCOLLECT,
    S_WCOMMIT,
    S_RREQ,
    S_RWAIT,
    S_RSHIFT
  } state_t;

  state_t             state_q, state_d;
  // The latched operation address doubles as the last-address register:
  // both are loaded with the resolved address on every accepted command.
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       wdata_q, wdata_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic               dout_valid_q, dout_valid_d;
  logic [ADDR_W-1:0]  cmd_addr_res;

  // Resolve the address a new command would use.
`ifdef BRIDGE_AUTO_INC_EN
  assign cmd_addr_res = cmd_inc ? (addr_q + ADDR_W'(1)) : cmd_addr;
`else
  logic unused_cmd_inc;
  assign unused_cmd_inc = cmd_inc;
  assign cmd_addr_res   = cmd_addr;
`endif

  // State and datapath registers.
  // NOTE: the assembled word and shift register are reset as well, because
  // ram_wdata and dout must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      shreg_q      <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      shreg_q      <= shreg_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    shreg_d      = shreg_q;

    if (cmd_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_d  = cmd_addr_res;
            cnt_d   = '0;
            state_d = cmd_write ? S_WCOLLECT : S_RREQ;
          end
        end
        S_WCOLLECT: begin
          if (din_valid) begin
            wdata_d[8*int'(cnt_q) +: 8] = din;
            if (cnt_q == LAST_LANE) begin
              cnt_d   = '0;
              state_d = S_WCOMMIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_WCOMMIT: state_d = S_IDLE;
        S_RREQ:    state_d = S_RWAIT;
        S_RWAIT: begin
          shreg_d = ram_rdata;
          cnt_d   = '0;
          state_d = S_RSHIFT;
        end
        S_RSHIFT: begin
          if (cnt_q == LAST_LANE) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            shreg_d = shreg_q >> 8;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // dout_valid is registered: it is high in exactly the cycles spent in RSHIFT.
    dout_valid_d = (state_d == S_RSHIFT);
  end

  // Outputs decoded from registers only.
  assign dout       = shreg_q[7:0];
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign ram_en     = (state_q == S_WCOMMIT) || (state_q == S_RREQ);
  assign ram_we     = {BYTES{state_q == S_WCOMMIT}};
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;

endmodule

// File: tb/tb_byte_serial_ram_bridge.sv
// tb_byte_serial_ram_bridge
//   Randomised bench with a scoreboard. Stimulus tasks compute the expected
//   RAM accesses and output bytes (with their cycle numbers) from a simple
//   word-array model and push them into queues; a negedge monitor pops and
//   compares whenever the bridge asserts ram_en or dout_valid.
module tb_byte_serial_ram_bridge;

  localparam int ADDR_W = 3;
  localparam int BYTES  = 4;
  localparam int W      = 8 * BYTES;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid, cmd_write, cmd_inc, cmd_abort;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        din;
  logic              din_valid;
  logic [7:0]        dout;
  logic              dout_valid, busy, ram_en;
  logic [BYTES-1:0]  ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [W-1:0]      ram_wdata;
  logic [W-1:0]      ram_rdata;

  byte_serial_ram_bridge #(.ADDR_W(ADDR_W), .BYTES(BYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_inc    (cmd_inc),
    .cmd_abort  (cmd_abort),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM macro: read-first, byte-writable, data one cycle after EN.
  logic [W-1:0] mem [DEPTH];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int l = 0; l < BYTES; l++)
        if (ram_we[l]) mem[ram_addr][8*l +: 8] <= ram_wdata[8*l +: 8];
    end
  end

  // Reference model state.
  logic [W-1:0]      ref_mem [DEPTH];
  logic [ADDR_W-1:0] last_addr;

  typedef struct {
    int                cyc;
    logic [BYTES-1:0]  we;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
  } ram_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } byte_exp_t;

  ram_exp_t  ram_q[$];
  byte_exp_t byte_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every RAM access and every output byte as it appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en) begin
        if (ram_q.size() == 0) begin
          check("ram_unexpected_en", 64'(ram_en), 64'(0));
        end else begin
          ram_exp_t e;
          e = ram_q.pop_front();
          check("ram_cycle", 64'(cyc), 64'(e.cyc));
          check("ram_we", 64'(ram_we), 64'(e.we));
          check("ram_addr", 64'(ram_addr), 64'(e.addr));
          if (e.we != '0) check("ram_wdata", 64'(ram_wdata), 64'(e.wdata));
        end
      end
      if (dout_valid) begin
        if (byte_q.size() == 0) begin
          check("dout_unexpected_valid", 64'(dout_valid), 64'(0));
        end else begin
          byte_exp_t b;
          b = byte_q.pop_front();
          check("dout_cycle", 64'(cyc), 64'(b.cyc));
          check("dout_byte", 64'(dout), 64'(b.b));
        end
      end
    end
  end

  // Address the bridge should use for a command, from the model's last address.
  function automatic logic [ADDR_W-1:0] resolve(input bit inc, input logic [ADDR_W-1:0] a);
`ifdef BRIDGE_AUTO_INC_EN
    if (inc) return ADDR_W'((int'(last_addr) + 1) % DEPTH);
`endif
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_inc   = 1'b0;
    cmd_abort = 1'b0;
    din_valid = 1'b0;
  endtask

  // Write: gap_lane inserts an idle cycle before that lane; abort_after aborts
  // in the cycle where lane abort_after would have been sent (-1 = neither).
  task automatic do_write(input logic [ADDR_W-1:0] a, input bit inc, input logic [W-1:0] word,
                          input int gap_lane, input int abort_after);
    logic [ADDR_W-1:0] ra;
    ra        = resolve(inc, a);
    last_addr = ra;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_inc = inc;
    din = 8'($urandom); din_valid = 1'b1;  // must be ignored in IDLE
    step();
    clear_cmd();
    check("wr_busy_after_accept", 64'(busy), 64'(1));
    for (int i = 0; i < BYTES; i++) begin
      if (i == abort_after) begin
        cmd_abort = 1'b1;
        step();
        clear_cmd();
        check("wr_abort_idle", 64'(busy), 64'(0));
        return;
      end
      if (i == gap_lane) begin
        din = 8'($urandom); din_valid = 1'b0;
        step();
      end
      din = word[8*i +: 8]; din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    ram_q.push_back('{cyc, {BYTES{1'b1}}, ra, word});
    ref_mem[ra] = word;
    step();
    check("wr_done_idle", 64'(busy), 64'(0));
  endtask

  // Read: pulse injects a command during RSHIFT; abort_at aborts while byte
  // abort_at is on dout; rst_at asserts reset while byte rst_at is on dout.
  task automatic do_read(input logic [ADDR_W-1:0] a, input bit inc, input bit pulse,
                         input int abort_at, input int rst_at);
    logic [ADDR_W-1:0] ra;
    logic [W-1:0]      w;
    int                n, nbytes;
    ra        = resolve(inc, a);
    last_addr = ra;
    n         = cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_inc = inc;
    step();
    clear_cmd();
    ram_q.push_back('{n + 1, '0, ra, '0});
    w      = ref_mem[ra];
    nbytes = BYTES;
    if (abort_at >= 0) nbytes = abort_at + 1;
    if (rst_at >= 0)   nbytes = rst_at;
    for (int i = 0; i < nbytes; i++) byte_q.push_back('{n + 3 + i, w[8*i +: 8]});
    while (cyc < n + 3 + BYTES) begin
      if (rst_at >= 0 && cyc == n + 3 + rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_dout_valid", 64'(dout_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ram_en", 64'(ram_en), 64'(0));
        last_addr = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        return;
      end
      if (abort_at >= 0 && cyc == n + 3 + abort_at) begin
        cmd_abort = 1'b1;
        step();
        clear_cmd();
        check("rd_abort_idle", 64'(busy), 64'(0));
        check("rd_abort_dout_valid", 64'(dout_valid), 64'(0));
        return;
      end
      if (pulse && cyc == n + 4) begin
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = ADDR_W'($urandom);
      end
      check("rd_busy", 64'(busy), 64'(1));
      step();
      clear_cmd();
    end
    check("rd_done_idle", 64'(busy), 64'(0));
  endtask

  task automatic idle_junk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      din = 8'($urandom); din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_cmd();
    cmd_addr = '0;
    din      = '0;
    last_addr = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 64'(dout), 64'(0));
    check("reset_dout_valid", 64'(dout_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ram_en", 64'(ram_en), 64'(0));
    check("reset_ram_we", 64'(ram_we), 64'(0));
    check("reset_ram_addr", 64'(ram_addr), 64'(0));
    check("reset_ram_wdata", 64'(ram_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), 1'b0, W'($urandom), -1, -1);

    // T1 / T2: directed write then read back.
    do_write(3'd2, 1'b0, 32'h4433_2211, -1, -1);
    do_read(3'd2, 1'b0, 1'b0, -1, -1);
    // T3: gap between the second and third byte.
    do_write(3'd5, 1'b0, 32'hA1B2_C3D4, 2, -1);
    do_read(3'd5, 1'b0, 1'b0, -1, -1);
    // T4: abort after two bytes, then a fresh write must start at lane 0.
    do_write(3'd6, 1'b0, 32'hDEAD_BEEF, -1, 2);
    do_write(3'd6, 1'b0, 32'h0102_0304, -1, -1);
    do_read(3'd6, 1'b0, 1'b0, -1, -1);
    // T5: command pulse during RSHIFT is ignored.
    do_read(3'd2, 1'b0, 1'b1, -1, -1);
    // T6: auto-increment wraps 7 -> 0 (or plain cmd_addr without the feature).
    do_read(3'd7, 1'b0, 1'b0, -1, -1);
    do_read(3'd5, 1'b1, 1'b0, -1, -1);
    // Abort beats cmd_valid in IDLE.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd1; cmd_abort = 1'b1;
    step();
    clear_cmd();
    check("abort_beats_cmd", 64'(busy), 64'(0));
    idle_junk(2);

    // Randomised mix.
    for (int k = 0; k < 40; k++) begin
      logic [ADDR_W-1:0] a;
      bit                inc;
      a   = ADDR_W'($urandom);
      inc = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        do_write(a, inc, W'($urandom),
                 ($urandom_range(2, 0) == 0) ? int'($urandom_range(BYTES - 1, 1)) : -1,
                 ($urandom_range(7, 0) == 0) ? int'($urandom_range(BYTES - 1, 0)) : -1);
      end else begin
        do_read(a, inc, 1'($urandom),
                ($urandom_range(7, 0) == 0) ? int'($urandom_range(BYTES - 1, 0)) : -1, -1);
      end
      idle_junk(int'($urandom_range(2, 0)));
    end

    // Reset while streaming the second byte.
    do_read(3'd2, 1'b0, 1'b0, -1, 1);
    do_read(3'd2, 1'b0, 1'b0, -1, -1);

    repeat (4) step();
    check("ram_queue_drained", 64'(ram_q.size()), 64'(0));
    check("byte_queue_drained", 64'(byte_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
